hyper_trans_scheduler: RTL
==========================

Name: hyper_trans_scheduler

Overview:
- Sits between the hyperbus front-end (AXI/TCDM adapter) and the hyperbus PHY.
- Accepts linear word-burst requests, decodes the target chip select from the runtime address mapping and splits bursts into segments no longer than the CS-low budget.
- Issues segments to the PHY one at a time and enforces the read-write recovery gap between consecutive CS-low periods.
- All timing and mapping inputs are driven from the hyperbus configuration register block.

Parameters:
- NR_CS, 2, number of chip selects / address regions
- ADDR_MAPPING_WIDTH, 64*NR_CS, width of packed mapping vector; region i is bits [64i+31:64i] for start and [64i+63:64i+32] for last
- LEN_WIDTH, 16, burst length field width in 16-bit words

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cfg_t_cs_max_i  in  32  max words per segment; value 0 is treated as 1
- cfg_t_rwr_i  in  32  idle cycles required between segments
- cfg_addr_mapping_i  in  ADDR_MAPPING_WIDTH  per-CS start/last byte addresses
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_addr_i  in  32  start byte address, word aligned
- req_len_i  in  LEN_WIDTH  burst length in words; 0 is illegal
- req_write_i  in  1  1=write, 0=read
- rsp_valid_o  out  1  one-cycle pulse, request fully completed or rejected
- rsp_err_o  out  1  qualified by rsp_valid_o; unmapped address, region overrun or len 0
- phy_valid_o  out  1  segment valid
- phy_ready_i  in  1  PHY accepts segment
- phy_addr_o  out  32  segment start byte address
- phy_len_o  out  LEN_WIDTH  segment length in words
- phy_write_o  out  1  segment direction
- phy_cs_o  out  NR_CS  one-hot chip select for segment
- phy_done_i  in  1  pulse: PHY released CS for current segment

Behaviour:
- Reset:
  - All outputs 0, FSM in IDLE, recovery counter 0.
  - Reset mid-transaction abandons it with no rsp pulse.
- States: IDLE, DECODE, ISSUE, WAIT_DONE, RECOVER, RESP.
- IDLE:
  - req_ready_o=1 only when the recovery counter is 0.
  - On handshake, latch addr, len, write, cfg_t_cs_max_i and cfg_t_rwr_i. Config changes during a transaction have no effect on it.
  - Go to DECODE.
- DECODE (1 cycle):
  - Find the lowest i with start_i <= addr <= last_i.
  - Error if no match, if len==0, or if addr + 2*len - 1 > last_i. All comparisons are 33-bit so wrap is detected as overrun.
  - On error go to RESP with err=1, without touching the PHY.
  - Otherwise latch cs one-hot and go to ISSUE.
- ISSUE:
  - phy_valid_o=1, phy_len_o = min(remaining, cs_max), phy_addr_o = current address.
  - Outputs hold stable until phy_ready_i.
  - On handshake: address += 2*seg_len, remaining -= seg_len, go to WAIT_DONE.
- WAIT_DONE:
  - Wait for phy_done_i.
  - Then load the recovery counter with t_rwr.
  - If remaining>0 go to RECOVER, else go to RESP.
- RECOVER:
  - Counter decrements each cycle.
  - When it is 0 go to ISSUE; t_rwr=0 gives a zero-cycle gap (RECOVER still costs 1 cycle).
- RESP:
  - rsp_valid_o pulses for 1 cycle, then IDLE.
  - After a successful request the recovery counter keeps counting in IDLE, so the next request is held off until it reaches 0.
- Latency: the first phy_valid_o is asserted 2 cycles after the request handshake.
- phy_done_i outside WAIT_DONE is ignored.
- phy_valid_o never asserts while the recovery counter is nonzero.

Decomposition:
- Package hyper_pkg:
  - hyper_seg_t struct (addr, len, write, cs)
  - state enum
  - constants HYPER_WORD_BYTES=2 and MAPPING_ENTRY_W=64
- Sub-module hyper_addr_decode: combinational region match, producing the one-hot cs, a hit flag and an overrun flag.

Test Plan:
- Defaults (map 0..3FFFFF / 400000..7FFFFF, cs_max=665, rwr=6), read addr 0x400010 len 8 -> single segment, cs=2'b10, len 8; rsp err=0 after done.
- cs_max=4, rwr=3, write addr 0x100 len 10 -> segments (0x100,4), (0x108,4), (0x110,2); each phy_valid_o at least 3 idle cycles after the prior phy_done_i.
- addr 0x800000 -> rsp_valid_o with err=1, phy_valid_o never asserted.
- addr 0x3FFFFC len 4 (overruns CS0 last 0x3FFFFF) -> err=1.
- Hold phy_ready_i low 5 cycles in ISSUE -> addr/len/cs stable throughout. Change cfg_t_cs_max_i mid-burst -> remaining segments still use the latched value.
- Assert rst_i during WAIT_DONE -> all outputs 0 next cycle, no rsp pulse; a new request then completes normally.

Source files
------------

// File: rtl/hyper_pkg.sv
`default_nettype none
// ==========================================================================
// hyper_pkg : shared types and constants for the hyperbus transaction scheduler
// Revision  : 1.0
// ==========================================================================
package hyper_pkg;

   localparam int HYPER_WORD_BYTES = 2;
   localparam int MAPPING_ENTRY_W  = 64;
   localparam int HYPER_NR_CS      = 2;
   localparam int HYPER_LEN_W      = 16;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_DECODE    = 3'd1,
      ST_ISSUE     = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_RECOVER   = 3'd4,
      ST_RESP      = 3'd5
   } state_t;

   // Segment context: addr is the next segment start, len the words still to issue
   typedef struct packed {
      logic [31:0]             addr;
      logic [HYPER_LEN_W-1:0]  len;
      logic                    write;
      logic [HYPER_NR_CS-1:0]  cs;
   } hyper_seg_t;

endpackage
`default_nettype wire

// File: rtl/hyper_addr_decode.sv
`default_nettype none
// ==========================================================================
// hyper_addr_decode : lowest-index region match with 33-bit overrun detection
// Revision          : 1.0
// ==========================================================================
module hyper_addr_decode
   import hyper_pkg::*;
#(
   parameter int NR_CS              = HYPER_NR_CS,
   parameter int ADDR_MAPPING_WIDTH = MAPPING_ENTRY_W * NR_CS,
   parameter int LEN_WIDTH          = HYPER_LEN_W
) (
   input  logic [ADDR_MAPPING_WIDTH-1:0] addr_mapping_i,
   input  logic [31:0]                   addr_i,
   input  logic [LEN_WIDTH-1:0]          len_i,
   output logic [NR_CS-1:0]              cs_o,
   output logic                          hit_o,
   output logic                          overrun_o
);

   logic [31:0]      region_last [NR_CS];
   logic [NR_CS-1:0] match;
   logic [31:0]      last_sel;
   logic [32:0]      end_addr;

   for (genvar i = 0; i < NR_CS; i++) begin : g_region
      logic [31:0] start_addr;
      assign start_addr     = addr_mapping_i[MAPPING_ENTRY_W*i +: 32];
      assign region_last[i] = addr_mapping_i[MAPPING_ENTRY_W*i+32 +: 32];
      assign match[i]       = (addr_i >= start_addr) && (addr_i <= region_last[i]);
   end

   // Extra top bit makes a burst that wraps past 4 GiB compare as an overrun
   assign end_addr = {1'b0, addr_i} + 33'(len_i) * 33'(HYPER_WORD_BYTES) - 33'd1;

   always_comb begin
      cs_o     = '0;
      hit_o    = 1'b0;
      last_sel = '0;
      for (int i = NR_CS - 1; i >= 0; i--) begin
         if (match[i]) begin
            cs_o     = '0;
            cs_o[i]  = 1'b1;
            hit_o    = 1'b1;
            last_sel = region_last[i];
         end
      end
   end

   assign overrun_o = hit_o && (end_addr > {1'b0, last_sel});

endmodule
`default_nettype wire

// File: rtl/hyper_trans_scheduler.sv
`default_nettype none
// ==========================================================================
// hyper_trans_scheduler : splits bursts into CS-bounded PHY segments with recovery gaps
// Revision              : 1.0
// ==========================================================================
module hyper_trans_scheduler
   import hyper_pkg::*;
#(
   parameter int NR_CS              = HYPER_NR_CS,
   parameter int ADDR_MAPPING_WIDTH = MAPPING_ENTRY_W * NR_CS,
   parameter int LEN_WIDTH          = HYPER_LEN_W
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [31:0]                   cfg_t_cs_max_i,
   input  logic [31:0]                   cfg_t_rwr_i,
   input  logic [ADDR_MAPPING_WIDTH-1:0] cfg_addr_mapping_i,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic [31:0]                   req_addr_i,
   input  logic [LEN_WIDTH-1:0]          req_len_i,
   input  logic                          req_write_i,
   output logic                          rsp_valid_o,
   output logic                          rsp_err_o,
   output logic                          phy_valid_o,
   input  logic                          phy_ready_i,
   output logic [31:0]                   phy_addr_o,
   output logic [LEN_WIDTH-1:0]          phy_len_o,
   output logic                          phy_write_o,
   output logic [NR_CS-1:0]              phy_cs_o,
   input  logic                          phy_done_i
);

   state_t           state, state_nxt;
   hyper_seg_t       seg;
   logic [31:0]      cs_max;
   logic [31:0]      t_rwr;
   logic [31:0]      rec_cnt;
   logic             err;

   logic [31:0]      cs_max_eff;
   logic [LEN_WIDTH-1:0] seg_len;
   logic [NR_CS-1:0] dec_cs;
   logic             dec_hit;
   logic             dec_overrun;
   logic             dec_err;
   logic             req_hs;
   logic             phy_hs;

   hyper_addr_decode #(
      .NR_CS              (NR_CS),
      .ADDR_MAPPING_WIDTH (ADDR_MAPPING_WIDTH),
      .LEN_WIDTH          (LEN_WIDTH)
   ) u_decode (
      .addr_mapping_i (cfg_addr_mapping_i),
      .addr_i         (seg.addr),
      .len_i          (seg.len),
      .cs_o           (dec_cs),
      .hit_o          (dec_hit),
      .overrun_o      (dec_overrun)
   );

   assign cs_max_eff = (cs_max == 32'd0) ? 32'd1 : cs_max;
   assign seg_len    = ({{(32-LEN_WIDTH){1'b0}}, seg.len} <= cs_max_eff) ?
                       seg.len : cs_max_eff[LEN_WIDTH-1:0];
   assign dec_err    = !dec_hit || dec_overrun || (seg.len == '0);

   assign req_ready_o = (state == ST_IDLE) && (rec_cnt == 32'd0) && !rst_i;
   assign req_hs      = req_valid_i && req_ready_o;
   assign phy_valid_o = (state == ST_ISSUE);
   assign phy_hs      = phy_valid_o && phy_ready_i;
   assign phy_addr_o  = phy_valid_o ? seg.addr  : '0;
   assign phy_len_o   = phy_valid_o ? seg_len   : '0;
   assign phy_write_o = phy_valid_o && seg.write;
   assign phy_cs_o    = phy_valid_o ? seg.cs    : '0;
   assign rsp_valid_o = (state == ST_RESP);
   assign rsp_err_o   = rsp_valid_o && err;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:      if (req_hs) state_nxt = ST_DECODE;
         ST_DECODE:    state_nxt = dec_err ? ST_RESP : ST_ISSUE;
         ST_ISSUE:     if (phy_ready_i) state_nxt = ST_WAIT_DONE;
         ST_WAIT_DONE: if (phy_done_i) state_nxt = (seg.len != '0) ? ST_RECOVER : ST_RESP;
         ST_RECOVER:   if (rec_cnt == 32'd0) state_nxt = ST_ISSUE;
         ST_RESP:      state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The recovery counter keeps running outside RECOVER so IDLE also honours the gap
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rec_cnt <= 32'd0;
      end else if ((state == ST_WAIT_DONE) && phy_done_i) begin
         rec_cnt <= t_rwr;
      end else if (rec_cnt != 32'd0) begin
         rec_cnt <= rec_cnt - 32'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         seg    <= '0;
         cs_max <= 32'd0;
         t_rwr  <= 32'd0;
         err    <= 1'b0;
      end else begin
         if (req_hs) begin
            seg.addr  <= req_addr_i;
            seg.len   <= req_len_i;
            seg.write <= req_write_i;
            seg.cs    <= '0;
            cs_max    <= cfg_t_cs_max_i;
            t_rwr     <= cfg_t_rwr_i;
            err       <= 1'b0;
         end
         if (state == ST_DECODE) begin
            seg.cs <= dec_cs;
            err    <= dec_err;
         end
         if (phy_hs) begin
            seg.addr <= seg.addr + 32'(seg_len) * 32'(HYPER_WORD_BYTES);
            seg.len  <= seg.len - seg_len;
         end
      end
   end

endmodule
`default_nettype wire
